// File: rtl/core_pkg.sv
// Shared core-wide widths, reset constants and the fetch-buffer entry type.
package core_pkg;

    localparam int unsigned ADDR_WIDTH  = 32'd32;
    localparam int unsigned INSTR_WIDTH = 32'd32;
    localparam int unsigned ENTRY_WIDTH = ADDR_WIDTH + INSTR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch advances one 4-byte instruction; wraps at the top of the address space.
    function automatic logic [ADDR_WIDTH-1:0] next_seq_pc(input logic [ADDR_WIDTH-1:0] pc);
        return pc + ADDR_WIDTH'(32'd4);
    endfunction

endpackage

// File: rtl/core_fetch_buffer_chk.sv
// Protocol checker: the credit scheme must never let a response meet a full buffer.
module core_fetch_buffer_chk (
    input logic clk,
    input logic rst,
    input logic resp_valid,
    input logic full
);

    property p_no_resp_when_full;
        @(posedge clk) disable iff (!rst) !(resp_valid && full);
    endproperty

    a_no_resp_when_full: assert property (p_no_resp_when_full);

endmodule

// File: rtl/core_fifo_sync.sv
// Single-clock circular FIFO with push/pop/clear and occupancy outputs.
// The head word reads as zero whenever the FIFO is empty.
module core_fifo_sync #(
    parameter int unsigned DEPTH = 32'd4,
    parameter int unsigned WIDTH = 32'd64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clear,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    logic [WIDTH-1:0] mem_r [DEPTH];
    ptr_t             wr_ptr_r;
    ptr_t             rd_ptr_r;
    cnt_t             count_r;
    logic             push_s;
    logic             pop_s;

    assign full    = (count_r == cnt_t'(DEPTH));
    assign empty   = (count_r == cnt_t'(1'b0));
    // A push into a full FIFO is dropped; clear overrides both push and pop.
    assign push_s  = push & ~full & ~clear;
    assign pop_s   = pop & ~empty & ~clear;
    assign count   = count_r;
    assign rd_data = empty ? WIDTH'(1'b0) : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; clear drops everything held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= ptr_t'(1'b0);
            rd_ptr_r <= ptr_t'(1'b0);
            count_r  <= cnt_t'(1'b0);
        end else if (clear) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= cnt_t'(1'b0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_t'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_t'(1'b1);
            end
            count_r <= count_r + cnt_t'(push_s) - cnt_t'(pop_s);
        end
    end

    // Entry storage; contents beyond the pointers are never observed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/core_fetch_buffer.sv
// Fetch-to-decode instruction buffer. Tags responses with sequential PCs,
// throttles fetch with credits, and drops stale responses after a redirect.
module core_fetch_buffer
    import core_pkg::*;
#(
    parameter int unsigned           DEPTH           = 32'd4,
    parameter int unsigned           MAX_OUTSTANDING = 32'd4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_fire,
    input  logic                   resp_valid,
    input  logic [INSTR_WIDTH-1:0] resp_instr,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  flush_pc,
    output logic                   fetch_stall,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [INSTR_WIDTH-1:0] dec_instr,
    output logic [ADDR_WIDTH-1:0]  dec_pc,
    output logic                   empty
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned SW = ((CW > OW) ? CW : OW) + 2;

    typedef logic [OW-1:0] out_t;
    typedef logic [SW-1:0] sum_t;

    out_t                  outstanding_r;
    out_t                  discard_r;
    out_t                  outstanding_next_s;
    logic [ADDR_WIDTH-1:0] next_pc_r;
    logic [CW-1:0]         count_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ENTRY_WIDTH-1:0] rd_data_s;
    fetch_entry_t          wr_entry_s;
    fetch_entry_t          rd_entry_s;
    sum_t                  credit_sum_s;

    // Responses still owed to the old path are swallowed instead of pushed.
    assign push_s     = resp_valid & (discard_r == out_t'(1'b0)) & ~flush;
    assign pop_s      = ~empty_s & dec_ready & ~flush;
    assign wr_entry_s = '{pc: next_pc_r, instr: resp_instr};
    assign rd_entry_s = fetch_entry_t'(rd_data_s);

    assign outstanding_next_s = outstanding_r + out_t'(req_fire) - out_t'(resp_valid);

    // Every slot that is filled, promised or owed to a discard counts against DEPTH.
    assign credit_sum_s = sum_t'(count_s) + sum_t'(outstanding_r) + sum_t'(discard_r);
    assign fetch_stall  = (credit_sum_s >= sum_t'(DEPTH)) |
                          (outstanding_r >= out_t'(MAX_OUTSTANDING));

    assign dec_valid = ~empty_s;
    assign empty     = empty_s;
    assign dec_instr = rd_entry_s.instr;
    assign dec_pc    = rd_entry_s.pc;

    core_fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push    (push_s),
        .pop     (pop_s),
        .clear   (flush),
        .wr_data (wr_entry_s),
        .rd_data (rd_data_s),
        .count   (count_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    core_fetch_buffer_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .resp_valid (resp_valid),
        .full       (full_s)
    );

    // In-flight request count, post-redirect discard credit and next PC tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_r <= out_t'(1'b0);
            discard_r     <= out_t'(1'b0);
            next_pc_r     <= RESET_PC;
        end else begin
            outstanding_r <= outstanding_next_s;
            if (flush) begin
                // Everything in flight after this edge, including a request
                // fired this cycle, belongs to the abandoned path.
                discard_r <= outstanding_next_s;
                next_pc_r <= flush_pc;
            end else if (resp_valid) begin
                if (discard_r != out_t'(1'b0)) begin
                    discard_r <= discard_r - out_t'(1'b1);
                end else begin
                    next_pc_r <= next_seq_pc(next_pc_r);
                end
            end
        end
    end

endmodule

// File: tb/tb_core_fetch_buffer.sv
// Self-checking bench for core_fetch_buffer: directed vector table, async
// reset checks, then constrained-random traffic against a queue-based model.
module tb_core_fetch_buffer;

    localparam logic        H = 1'b1;
    localparam logic        L = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } mentry_t;

    typedef struct {
        logic        rf;
        logic        rv;
        logic [31:0] instr;
        logic        fl;
        logic [31:0] fpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        est;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_fire;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_stall;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        empty;

    int n_tests;
    int n_fails;

    mentry_t     mq[$];
    int          m_out;
    int          m_disc;
    logic [31:0] m_pc;
    vec_t        vecs[$];

    core_fetch_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .req_fire    (req_fire),
        .resp_valid  (resp_valid),
        .resp_instr  (resp_instr),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_stall (fetch_stall),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .empty       (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_out  = 0;
        m_disc = 0;
        m_pc   = 32'h0;
    endfunction

    function automatic logic model_stall();
        return ((mq.size() + m_out + m_disc) >= 4) || (m_out >= 4);
    endfunction

    // Behaviour at a clock edge, from the rules: flush wins, else pop then push/discard.
    function automatic void model_edge(input logic rf, input logic rv, input logic [31:0] ins,
                                       input logic fl, input logic [31:0] fpc, input logic rdy);
        int new_out;
        new_out = m_out + int'(rf) - int'(rv);
        if (fl) begin
            mq.delete();
            m_disc = new_out;
            m_pc   = fpc;
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (rv) begin
                if (m_disc == 0) begin
                    mq.push_back('{pc: m_pc, instr: ins});
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_disc = m_disc - 1;
                end
            end
        end
        m_out = new_out;
    endfunction

    task automatic check_model();
        check("valid", dec_valid, (mq.size() != 0));
        check("empty", empty, (mq.size() == 0));
        check("stall", fetch_stall, model_stall());
        if (mq.size() != 0) begin
            check("pc", dec_pc, mq[0].pc);
            check("instr", dec_instr, mq[0].instr);
        end else begin
            check("pc_idle", dec_pc, 32'h0);
            check("instr_idle", dec_instr, 32'h0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, dec_valid, 32'h0);
        check({tag, "_empty"}, empty, 32'h1);
        check({tag, "_stall"}, fetch_stall, 32'h0);
        check({tag, "_pc"}, dec_pc, 32'h0);
        check({tag, "_instr"}, dec_instr, 32'h0);
    endtask

    task automatic step(input logic rf, input logic rv, input logic [31:0] ins,
                        input logic fl, input logic [31:0] fpc, input logic rdy);
        req_fire   = rf;
        resp_valid = rv;
        resp_instr = ins;
        flush      = fl;
        flush_pc   = fpc;
        dec_ready  = rdy;
        @(posedge clk);
        model_edge(rf, rv, ins, fl, fpc, rdy);
        #1;
        check_model();
    endtask

    task automatic add_vec(input logic rf, input logic rv, input logic [31:0] ins,
                           input logic fl, input logic [31:0] fpc, input logic rdy,
                           input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                           input logic est);
        vecs.push_back('{rf: rf, rv: rv, instr: ins, fl: fl, fpc: fpc, rdy: rdy,
                         ev: ev, epc: epc, einstr: einstr, est: est});
    endtask

    initial begin
        n_tests = 0;
        n_fails = 0;

        // First response after reset, then drain.
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, L);
        add_vec(L, H, 32'h13,       L, Z, L,  H, 32'h0, 32'h13, L);
        add_vec(L, L, Z,            L, Z, H,  L, Z, Z, L);
        // Fill with dec_ready low until stall.
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, L);
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, L);
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, L);
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, H);
        add_vec(L, H, 32'hA0,       L, Z, L,  H, 32'h4, 32'hA0, H);
        add_vec(L, H, 32'hA1,       L, Z, L,  H, 32'h4, 32'hA0, H);
        add_vec(L, H, 32'hA2,       L, Z, L,  H, 32'h4, 32'hA0, H);
        add_vec(L, H, 32'hA3,       L, Z, L,  H, 32'h4, 32'hA0, H);
        // Drain in order; stall drops after the first pop.
        add_vec(L, L, Z,            L, Z, H,  H, 32'h8, 32'hA1, L);
        add_vec(L, L, Z,            L, Z, H,  H, 32'hC, 32'hA2, L);
        add_vec(L, L, Z,            L, Z, H,  H, 32'h10, 32'hA3, L);
        add_vec(L, L, Z,            L, Z, H,  L, Z, Z, L);
        // Streaming push+pop every cycle.
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, L);
        add_vec(H, H, 32'hB0,       L, Z, L,  H, 32'h14, 32'hB0, L);
        add_vec(H, H, 32'hB1,       L, Z, H,  H, 32'h18, 32'hB1, L);
        add_vec(H, H, 32'hB2,       L, Z, H,  H, 32'h1C, 32'hB2, L);
        add_vec(L, H, 32'hB3,       L, Z, H,  H, 32'h20, 32'hB3, L);
        add_vec(L, L, Z,            L, Z, H,  L, Z, Z, L);
        // Flush with two in flight plus a request in the flush cycle.
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, L);
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, L);
        add_vec(H, L, Z,            H, 32'h100, L,  L, Z, Z, H);
        add_vec(L, H, 32'hDEAD,     L, Z, L,  L, Z, Z, H);
        add_vec(L, H, 32'hDEAD,     L, Z, L,  L, Z, Z, L);
        add_vec(L, H, 32'hDEAD,     L, Z, L,  L, Z, Z, L);
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, L);
        add_vec(L, H, 32'hC0,       L, Z, L,  H, 32'h100, 32'hC0, L);
        // Flush together with a response and a pop.
        add_vec(H, L, Z,            L, Z, L,  H, 32'h100, 32'hC0, L);
        add_vec(H, H, 32'hC1,       L, Z, L,  H, 32'h100, 32'hC0, L);
        add_vec(L, H, 32'hEE,       H, 32'h200, H,  L, Z, Z, L);
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, L);
        add_vec(L, H, 32'hC2,       L, Z, L,  H, 32'h200, 32'hC2, L);
        // PC wrap at the top of the address space.
        add_vec(L, L, Z,            H, 32'hFFFF_FFFC, L,  L, Z, Z, L);
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, L);
        add_vec(H, L, Z,            L, Z, L,  L, Z, Z, L);
        add_vec(L, H, 32'hD0,       L, Z, L,  H, 32'hFFFF_FFFC, 32'hD0, L);
        add_vec(L, H, 32'hD1,       L, Z, H,  H, 32'h0, 32'hD1, L);

        // Reset held with a response pending must leave everything idle.
        rst        = 1'b0;
        req_fire   = 1'b0;
        resp_valid = 1'b1;
        resp_instr = 32'h13;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        dec_ready  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst        = 1'b1;
        resp_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rf, vecs[i].rv, vecs[i].instr, vecs[i].fl, vecs[i].fpc, vecs[i].rdy);
            check($sformatf("vec%0d_valid", i), dec_valid, vecs[i].ev);
            check($sformatf("vec%0d_empty", i), empty, !vecs[i].ev);
            check($sformatf("vec%0d_pc", i), dec_pc, vecs[i].epc);
            check($sformatf("vec%0d_instr", i), dec_instr, vecs[i].einstr);
            check($sformatf("vec%0d_stall", i), fetch_stall, vecs[i].est);
        end

        // Asynchronous reset between edges with an entry held.
        req_fire   = 1'b0;
        resp_valid = 1'b0;
        flush      = 1'b0;
        dec_ready  = 1'b0;
        #2;
        check("pre_async_valid", dec_valid, 32'h1);
        rst = 1'b0;
        #1;
        check_reset_outputs("async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        // Constrained-random traffic that obeys the stall and in-flight rules.
        for (int c = 0; c < 3000; c++) begin
            logic rf;
            logic rv;
            logic fl;
            rf = !model_stall() && ($urandom_range(0, 1) == 1);
            rv = (m_out > 0) && ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 19) == 0);
            step(rf, rv, $urandom, fl, $urandom, ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
